mux_scan_sequencer: RTL and testbench

Downstream consumer of the divided clock. Samples the divided clock `slow_clk` in the `clk_in` domain and detects its rising edges. Each detected edge steps the 3-bit select of the 8-to-1 multiplexer and captures that mux's 1-bit output. After 8 edges it presents the assembled byte with a one-cycle valid pulse. Sits between the clock divider and the mux/edge-triggered register bank.

---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/slow_tick_detect.sv | 40 ++++
 rtl/mux_scan_sequencer.sv | 94 +++++++++
 tb/tb_mux_scan_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux scan sequencer.
// Config macro used by this slice: MUX_SCAN_SYNC_EN (see slow_tick_detect).
package mux_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int unsigned NUM_INPUTS = 8;
  localparam int unsigned SEL_W      = 3;

endpackage

// File: rtl/slow_tick_detect.sv
// Rising-edge strobe of the divided clock, sampled as a level in the clk_in domain.
// MUX_SCAN_SYNC_EN adds a 2-flop synchronizer (two extra cycles of tick latency).
module slow_tick_detect (
  input  logic clk_in,
  input  logic reset,
  input  logic slow_clk,
  output logic tick
);

  logic slow_clk_s;
  logic slow_prev_q;

`ifdef MUX_SCAN_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], slow_clk};
    end
  end

  assign slow_clk_s = sync_q[1];
`else
  // Divider output is already registered on clk_in, so it is used directly.
  assign slow_clk_s = slow_clk;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      slow_prev_q <= 1'b0;
    end else begin
      slow_prev_q <= slow_clk_s;
    end
  end

  assign tick = slow_clk_s & ~slow_prev_q;

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps an 8-to-1 mux select on each slow_clk rising edge and assembles a byte frame.
// Tick latency depends on MUX_SCAN_SYNC_EN inside slow_tick_detect.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             start,
  input  logic             stop,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic [7:0]       data_out,
  output logic             frame_valid,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_INPUTS - 1);

  scan_state_t            state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [NUM_INPUTS-1:0]  shadow_q, shadow_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   tick;

  slow_tick_detect u_tick (
    .clk_in   (clk_in),
    .reset    (reset),
    .slow_clk (slow_clk),
    .tick     (tick)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d    = '0;
          shadow_d = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        // stop wins over a coincident tick, even the frame-completing one
        if (stop) begin
          sel_d    = '0;
          shadow_d = '0;
          state_d  = IDLE;
        end else if (tick) begin
          shadow_d[sel_q] = mux_out;
          if (sel_q == SEL_LAST) begin
            data_d   = {mux_out, shadow_q[6:0]};
            valid_d  = 1'b1;
            sel_d    = '0;
            shadow_d = '0;
            state_d  = CONTINUOUS ? SCAN : IDLE;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel         = sel_q;
  assign data_out    = data_q;
  assign frame_valid = valid_q;
  assign busy        = (state_q == SCAN);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: one continuous and one single-shot instance driven by shared controls.
// Honours MUX_SCAN_SYNC_EN for the expected tick latency.
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, slow_clk, start, stop;
  logic [7:0] pat_c, pat_s;
  logic       mux_c, mux_s;
  logic [2:0] sel_c, sel_s;
  logic [7:0] data_c, data_s;
  logic       valid_c, valid_s, busy_c, busy_s;
  int         vcnt_c = 0;
  int         vcnt_s = 0;
  int         checks = 0;
  int         errors = 0;
  int         base_c, base_s;

  always #5 clk = ~clk;

  assign mux_c = pat_c[sel_c];
  assign mux_s = pat_s[sel_s];

  mux_scan_sequencer #(.CONTINUOUS(1'b1)) u_dut_c (
    .clk_in(clk), .reset(reset), .slow_clk(slow_clk), .start(start), .stop(stop),
    .mux_out(mux_c), .sel(sel_c), .data_out(data_c), .frame_valid(valid_c), .busy(busy_c)
  );

  mux_scan_sequencer #(.CONTINUOUS(1'b0)) u_dut_s (
    .clk_in(clk), .reset(reset), .slow_clk(slow_clk), .start(start), .stop(stop),
    .mux_out(mux_s), .sel(sel_s), .data_out(data_s), .frame_valid(valid_s), .busy(busy_s)
  );

  // Counts cycles with frame_valid high, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (valid_c) vcnt_c++;
    if (valid_s) vcnt_s++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_pulse();
    slow_clk = 1'b1;
    cyc(2);
    slow_clk = 1'b0;
    cyc(2);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; slow_clk = 1'b0; start = 1'b0; stop = 1'b0;
    pat_c = 8'h00; pat_s = 8'h00;
    cyc(3);
    reset = 1'b0;
    cyc(1);

    check("rst_sel", 32'(sel_c), 32'd0);
    check("rst_data", 32'(data_c), 32'h00);
    check("rst_valid", 32'(valid_c), 32'd0);
    check("rst_busy", 32'(busy_c), 32'd0);
    check("rst_busy_s", 32'(busy_s), 32'd0);

    // Basic frame on both instances
    pat_c = 8'hA5; pat_s = 8'hA5;
    base_c = vcnt_c; base_s = vcnt_s;
    do_start();
    check("start_busy", 32'(busy_c), 32'd1);
    check("start_sel", 32'(sel_c), 32'd0);
    repeat (3) tick_pulse();
    check("mid_sel", 32'(sel_c), 32'd3);
    repeat (5) tick_pulse();
    cyc(2);
    check("frame_data", 32'(data_c), 32'hA5);
    check("frame_vcnt", 32'(vcnt_c - base_c), 32'd1);
    check("frame_sel", 32'(sel_c), 32'd0);
    check("frame_busy_c", 32'(busy_c), 32'd1);
    check("frame_data_s", 32'(data_s), 32'hA5);
    check("frame_busy_s", 32'(busy_s), 32'd0);

    // Continuous: 3C then C3; single-shot sees all 16 ticks but one frame
    reset = 1'b1; cyc(1); reset = 1'b0;
    pat_c = 8'h3C; pat_s = 8'h3C;
    base_c = vcnt_c; base_s = vcnt_s;
    do_start();
    repeat (8) tick_pulse();
    check("cont_data1", 32'(data_c), 32'h3C);
    check("cont_vcnt1", 32'(vcnt_c - base_c), 32'd1);
    check("cont_busy1", 32'(busy_c), 32'd1);
    pat_c = 8'hC3; pat_s = 8'hFF;
    tick_pulse();
    check("ss_9th_sel", 32'(sel_s), 32'd0);
    repeat (7) tick_pulse();
    cyc(2);
    check("cont_data2", 32'(data_c), 32'hC3);
    check("cont_vcnt2", 32'(vcnt_c - base_c), 32'd2);
    check("cont_busy2", 32'(busy_c), 32'd1);
    check("ss_data", 32'(data_s), 32'h3C);
    check("ss_vcnt", 32'(vcnt_s - base_s), 32'd1);
    check("ss_busy", 32'(busy_s), 32'd0);

    // Reset mid-frame at sel=5
    pat_c = 8'h00;
    repeat (5) tick_pulse();
    check("pre_rst_sel", 32'(sel_c), 32'd5);
    reset = 1'b1; cyc(1);
    check("mrst_sel", 32'(sel_c), 32'd0);
    check("mrst_busy", 32'(busy_c), 32'd0);
    check("mrst_data", 32'(data_c), 32'h00);
    check("mrst_valid", 32'(valid_c), 32'd0);
    reset = 1'b0;
    repeat (2) tick_pulse();
    check("idle_tick_sel", 32'(sel_c), 32'd0);
    check("idle_tick_busy", 32'(busy_c), 32'd0);

    // Stop coincident with the sel==7 tick
    pat_c = 8'h5A;
    do_start();
    repeat (8) tick_pulse();
    check("pre_stop_data", 32'(data_c), 32'h5A);
    pat_c = 8'hFF;
    repeat (7) tick_pulse();
    check("pre_stop_sel", 32'(sel_c), 32'd7);
    base_c = vcnt_c;
    slow_clk = 1'b1;
    cyc(LAT);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(1);
    slow_clk = 1'b0;
    cyc(4);
    check("stop_vcnt", 32'(vcnt_c - base_c), 32'd0);
    check("stop_data", 32'(data_c), 32'h5A);
    check("stop_busy", 32'(busy_c), 32'd0);
    check("stop_sel", 32'(sel_c), 32'd0);

    // start and stop together in IDLE starts the scan
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy_c), 32'd1);

    // Long high level: one step, acting at E+LAT
    slow_clk = 1'b1;
    cyc(LAT);
    check("lat_before", 32'(sel_c), 32'd0);
    cyc(1);
    check("lat_at", 32'(sel_c), 32'd1);
    cyc(18);
    slow_clk = 1'b0;
    cyc(4);
    check("long_high_sel", 32'(sel_c), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
